apb_cmd_buf: RTL and testbench
==============================

# apb_cmd_buf

Command/response buffer sitting directly upstream of the APB master state machine. It accepts write and read commands from the host side and queues writes in a first-word-fall-through FIFO presented on the master's `wreq`/`wbuffdata`/`wbuffaddr`/`wbuffread` port. It holds a single read request on `rreq`/`rbuffaddr` and captures the returned `rbuffdata`/`resp` into a response register for the host. It preserves host command order and counts write errors reported by the master.

## Interface
- `DEPTH`, 8: write FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the write-error counter.

Ports:
- `pclk`  in  1  clock; all logic on the rising edge.
- `prst`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  host command valid.
- `cmd_ready`  out  1  host command accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  command address.
- `cmd_wdata`  in  32  write data; ignored for reads.
- `rsp_valid`  out  1  read response held.
- `rsp_ready`  in  1  host consumes response.
- `rsp_rdata`  out  32  read data.
- `rsp_err`  out  1  slave error for that read.
- `wreq`  out  1  write FIFO not empty.
- `wbuffdata`  out  32  head entry data, combinational from the FIFO.
- `wbuffaddr`  out  32  head entry address, combinational from the FIFO.
- `wbuffread`  in  1  pop the head entry.
- `rreq`  out  1  read request to the master.
- `rbuffaddr`  out  32  pending read address.
- `rbuffwrite`  in  1  read data valid from the master.
- `rbuffdata`  in  32  read data from the master.
- `done`  in  1  transfer-complete pulse from the master.
- `resp`  in  1  `pslverr`, aligned with `done`.
- `penable`, `pready`, `pwrite`  in  1 each  snooped APB bus signals.
- `wr_err_cnt`  out  CNT_W  saturating count of errored writes.
- `idle`  out  1  FIFO empty, no read pending, no response held.

## Operation
- Write FIFO: `DEPTH` x 64 bits holding {addr, data}. Read/write pointers are `clog2(DEPTH)` bits and wrap naturally. Count is `clog2(DEPTH)+1` bits.
  - Push on an accepted write.
  - Pop on `wbuffread & wreq`. `wbuffread` while empty is ignored.
  - Simultaneous push and pop: count unchanged.
- `cmd_ready` is combinational:
  - Write: `!full & !rd_pend`.
  - Read: `!rd_pend`.
- Read state: registers `rd_pend`, `rd_issued`, `rd_addr`.
  - An accepted read sets `rd_pend` and loads `rd_addr`.
  - `rbuffaddr = rd_addr`.
  - `rreq = rd_pend & !rd_issued & !wreq & !(penable & pready & !pwrite)`. The snoop term drops `rreq` in the bus completion cycle, so the master cannot re-issue the same read.
  - `rbuffwrite` sets `rd_issued`, loads `rsp_rdata <= rbuffdata`, `rsp_err <= resp`, and `rsp_valid <= 1`.
  - `rsp_valid & rsp_ready` clears `rsp_valid`, `rd_pend` and `rd_issued`.
- Ordering:
  - Writes are blocked while a read is pending.
  - A read waits until the FIFO is empty. A write already in ACCESS completes before the master samples `rreq`.
- Write errors: `done & !rbuffwrite & resp` increments `wr_err_cnt`, saturating at all-ones.
- `idle = !wreq & !rd_pend & !rsp_valid`.

## Timing
- Reset values:
  - Pointers and count 0; `wreq` 0.
  - `rd_pend`, `rd_issued`, `rsp_valid`, `rsp_err`, `rsp_rdata`, `rd_addr`, `wr_err_cnt` all 0.
  - `idle` 1.
  - FIFO storage is not reset.
- Reset mid-transfer discards all queued and pending commands. Responses arriving after reset deasserts are ignored unless `rd_pend` is set.
- Push to `wreq` high: 1 cycle; `wreq` is combinational on the registered count.
- Pop: the next head is visible on `wbuffdata`/`wbuffaddr` the cycle after `wbuffread`.
- Read accept to `rreq` high: 1 cycle when the FIFO is empty.
- `rbuffwrite` to `rsp_valid` high: 1 cycle.
- After `rsp_ready`, a new read can be accepted the next cycle.
- `cmd_ready` may depend on current-cycle state only, never on `cmd_valid`.

## Test plan
- Reset, then 3 writes (0x10/0xA, 0x14/0xB, 0x18/0xC) with `wbuffread` pulses 2 cycles apart -> heads presented in order; `wreq` falls after the 3rd pop; `idle` returns to 1.
- Fill `DEPTH` writes with no pops -> `cmd_ready` low for writes; the 9th write is held; one pop -> accepted next cycle; pointers wrap, data intact.
- Read 0x20 while 2 writes queued -> `rreq` stays 0 until the FIFO is empty. `rbuffwrite` with 0xDEAD, `resp` 0 -> `rsp_valid` 1, `rsp_rdata` 0xDEAD. Writes blocked until `rsp_ready`.
- Bus completion cycle for the read (`penable=1`, `pready=1`, `pwrite=0`) -> `rreq` 0 in that same cycle; exactly one read is observed.
- 300 write `done` pulses with `resp=1` -> `wr_err_cnt` saturates at 255. A read `done` with `resp=1` -> `rsp_err` 1, counter unchanged.
- Assert `prst` asynchronously mid-read with 4 writes queued -> all outputs at reset values immediately; a subsequent `rbuffwrite` does not set `rsp_valid`.

Source files
------------

// File: rtl/apb_cmd_buf.sv
// Host-side command/response buffer feeding an APB master: FIFO-queued writes,
// a single outstanding read with a held response, and a saturating write-error count.
module apb_cmd_buf #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             wreq,
  output logic [31:0]      wbuffdata,
  output logic [31:0]      wbuffaddr,
  input  logic             wbuffread,
  output logic             rreq,
  output logic [31:0]      rbuffaddr,
  input  logic             rbuffwrite,
  input  logic [31:0]      rbuffdata,
  input  logic             done,
  input  logic             resp,
  input  logic             penable,
  input  logic             pready,
  input  logic             pwrite,
  output logic [CNT_W-1:0] wr_err_cnt,
  output logic             idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, push, pop, rd_accept, rsp_take, wr_err;
  logic          rd_pend, rd_issued;
  logic [31:0]   rd_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign full      = (count == FULL_CNT);
  assign wreq      = (count != '0);
  assign cmd_ready = cmd_write ? (!full && !rd_pend) : !rd_pend;
  assign push      = cmd_valid && cmd_ready && cmd_write;
  assign rd_accept = cmd_valid && cmd_ready && !cmd_write;
  assign pop       = wbuffread && wreq;
  assign rsp_take  = rsp_valid && rsp_ready;
  assign wr_err    = done && !rbuffwrite && resp;

  assign {wbuffaddr, wbuffdata} = mem[rptr];
  assign rbuffaddr = rd_addr;
  // Masked in the read's completion cycle so the master never re-issues it.
  assign rreq = rd_pend && !rd_issued && !wreq && !(penable && pready && !pwrite);
  assign idle = !wreq && !rd_pend && !rsp_valid;

  always_ff @(posedge pclk) begin
    if (push) mem[wptr] <= {cmd_addr, cmd_wdata};
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rd_pend   <= 1'b0;
      rd_issued <= 1'b0;
      rd_addr   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (rd_accept) begin
        rd_pend <= 1'b1;
        rd_addr <= cmd_addr;
      end
      // Stray read data with no read outstanding (e.g. after reset) is dropped.
      if (rbuffwrite && rd_pend) begin
        rd_issued <= 1'b1;
        rsp_valid <= 1'b1;
        rsp_rdata <= rbuffdata;
        rsp_err   <= resp;
      end
      if (rsp_take) begin
        rsp_valid <= 1'b0;
        rd_pend   <= 1'b0;
        rd_issued <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) wr_err_cnt <= '0;
    else if (wr_err) wr_err_cnt <= sat_inc(wr_err_cnt);
  end

endmodule

// File: tb/tb_apb_cmd_buf.sv
// Directed self-checking bench for apb_cmd_buf with hand-computed expectations.
module tb_apb_cmd_buf;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid, cmd_write, rsp_ready, wbuffread, rbuffwrite;
  logic        done, resp, penable, pready, pwrite;
  logic [31:0] cmd_addr, cmd_wdata, rbuffdata;
  logic        cmd_ready, rsp_valid, rsp_err, wreq, rreq, idle;
  logic [31:0] rsp_rdata, wbuffdata, wbuffaddr, rbuffaddr;
  logic [7:0]  wr_err_cnt;

  int total  = 0;
  int passed = 0;

  apb_cmd_buf #(.DEPTH(8), .CNT_W(8)) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wreq(wreq), .wbuffdata(wbuffdata), .wbuffaddr(wbuffaddr), .wbuffread(wbuffread),
    .rreq(rreq), .rbuffaddr(rbuffaddr), .rbuffwrite(rbuffwrite), .rbuffdata(rbuffdata),
    .done(done), .resp(resp), .penable(penable), .pready(pready), .pwrite(pwrite),
    .wr_err_cnt(wr_err_cnt), .idle(idle)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then settle so registered outputs are stable.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic write_cmd(input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    prst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; wbuffread = 0; rbuffwrite = 0; rbuffdata = 0;
    done = 0; resp = 0; penable = 0; pready = 0; pwrite = 0;

    // Reset state
    tick(); tick();
    chk("rst_wreq", 32'(wreq), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rreq", 32'(rreq), 0);
    chk("rst_errcnt", 32'(wr_err_cnt), 0);
    prst = 1'b0;
    tick();
    cmd_write = 1'b1; settle();
    chk("rst_cmd_ready", 32'(cmd_ready), 1);

    // Three writes, popped two cycles apart
    write_cmd(32'h10, 32'hA);
    chk("w1_wreq", 32'(wreq), 1);
    write_cmd(32'h14, 32'hB);
    write_cmd(32'h18, 32'hC);
    chk("w3_head_addr", wbuffaddr, 32'h10);
    chk("w3_head_data", wbuffdata, 32'hA);
    chk("w3_idle", 32'(idle), 0);
    wbuffread = 1; tick(); wbuffread = 0;
    chk("pop1_addr", wbuffaddr, 32'h14);
    chk("pop1_data", wbuffdata, 32'hB);
    tick();
    wbuffread = 1; tick(); wbuffread = 0;
    chk("pop2_addr", wbuffaddr, 32'h18);
    chk("pop2_data", wbuffdata, 32'hC);
    chk("pop2_wreq", 32'(wreq), 1);
    tick();
    wbuffread = 1; tick(); wbuffread = 0;
    chk("pop3_wreq", 32'(wreq), 0);
    chk("pop3_idle", 32'(idle), 1);
    wbuffread = 1; tick(); wbuffread = 0;
    chk("empty_pop_ignored", 32'(wreq), 0);

    // Fill the FIFO, hold a ninth write, pop once to let it in
    for (int i = 0; i < 8; i++) write_cmd(32'h100 + 32'(i * 4), 32'h1000 + 32'(i));
    cmd_write = 1; settle();
    chk("full_wr_ready", 32'(cmd_ready), 0);
    cmd_write = 0; settle();
    chk("full_rd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h200; cmd_wdata = 32'h9999;
    tick();
    chk("held_ready", 32'(cmd_ready), 0);
    chk("held_head", wbuffaddr, 32'h100);
    wbuffread = 1;
    tick();
    wbuffread = 0; settle();
    chk("after_pop_ready", 32'(cmd_ready), 1);
    chk("after_pop_head", wbuffaddr, 32'h104);
    tick();
    cmd_valid = 0; cmd_write = 1; settle();
    chk("refull_ready", 32'(cmd_ready), 0);
    for (int i = 1; i < 8; i++) begin
      chk("wrap_addr", wbuffaddr, 32'h100 + 32'(i * 4));
      chk("wrap_data", wbuffdata, 32'h1000 + 32'(i));
      wbuffread = 1; tick(); wbuffread = 0;
    end
    chk("ninth_addr", wbuffaddr, 32'h200);
    chk("ninth_data", wbuffdata, 32'h9999);
    wbuffread = 1; tick(); wbuffread = 0;
    chk("drain_wreq", 32'(wreq), 0);

    // Read waits behind queued writes and blocks new writes
    write_cmd(32'h30, 32'h1);
    write_cmd(32'h34, 32'h2);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20; settle();
    chk("rd_accept_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
    chk("rd_wait_rreq", 32'(rreq), 0);
    chk("rd_addr", rbuffaddr, 32'h20);
    cmd_write = 1; settle();
    chk("rd_blocks_wr", 32'(cmd_ready), 0);
    cmd_write = 0; settle();
    chk("rd_blocks_rd", 32'(cmd_ready), 0);
    wbuffread = 1; tick();
    chk("rd_wait_rreq2", 32'(rreq), 0);
    tick(); wbuffread = 0; settle();
    chk("rd_rreq_up", 32'(rreq), 1);
    tick();
    chk("rd_rreq_hold", 32'(rreq), 1);

    // Completion cycle masks rreq in the same cycle
    penable = 1; pready = 1; pwrite = 0; done = 1; resp = 0;
    rbuffwrite = 1; rbuffdata = 32'hDEAD; settle();
    chk("cmpl_rreq_mask", 32'(rreq), 0);
    tick();
    penable = 0; pready = 0; done = 0; rbuffwrite = 0; settle();
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_rdata", rsp_rdata, 32'hDEAD);
    chk("rsp_err0", 32'(rsp_err), 0);
    chk("issued_rreq", 32'(rreq), 0);
    chk("rd_errcnt", 32'(wr_err_cnt), 0);
    cmd_write = 1; settle();
    chk("rsp_blocks_wr", 32'(cmd_ready), 0);
    tick();
    chk("rsp_still_valid", 32'(rsp_valid), 1);
    rsp_ready = 1; tick(); rsp_ready = 0;
    chk("rsp_cleared", 32'(rsp_valid), 0);
    chk("rsp_idle", 32'(idle), 1);
    chk("rsp_wr_ready", 32'(cmd_ready), 1);

    // Write-error counting, errored read does not count
    for (int i = 0; i < 5; i++) begin
      done = 1; resp = 1; tick();
    end
    done = 0; resp = 0;
    chk("errcnt5", 32'(wr_err_cnt), 5);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40; tick(); cmd_valid = 0;
    chk("rd2_rreq", 32'(rreq), 1);
    rbuffwrite = 1; rbuffdata = 32'h1234; done = 1; resp = 1; tick();
    rbuffwrite = 0; done = 0; resp = 0; settle();
    chk("rd2_err", 32'(rsp_err), 1);
    chk("rd2_data", rsp_rdata, 32'h1234);
    chk("rd2_errcnt", 32'(wr_err_cnt), 5);
    rsp_ready = 1; tick(); rsp_ready = 0;
    for (int i = 0; i < 295; i++) begin
      done = 1; resp = 1; tick();
    end
    done = 0; resp = 0;
    chk("errcnt_sat", 32'(wr_err_cnt), 255);
    done = 1; resp = 1; tick(); done = 0; resp = 0;
    chk("errcnt_sat_hold", 32'(wr_err_cnt), 255);

    // Asynchronous reset mid-read with queued writes
    for (int i = 0; i < 4; i++) write_cmd(32'h50 + 32'(i * 4), 32'(i));
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h60; settle();
    chk("pre_rst_rd_ready", 32'(cmd_ready), 1);
    tick(); cmd_valid = 0;
    chk("pre_rst_idle", 32'(idle), 0);
    #2 prst = 1'b1;
    #1;
    chk("arst_wreq", 32'(wreq), 0);
    chk("arst_idle", 32'(idle), 1);
    chk("arst_rreq", 32'(rreq), 0);
    chk("arst_raddr", rbuffaddr, 0);
    chk("arst_errcnt", 32'(wr_err_cnt), 0);
    chk("arst_rdata", rsp_rdata, 0);
    chk("arst_rsp_err", 32'(rsp_err), 0);
    tick();
    prst = 1'b0;
    rbuffwrite = 1; rbuffdata = 32'h55; resp = 1;
    tick();
    rbuffwrite = 0; resp = 0; settle();
    chk("post_rst_stray_rsp", 32'(rsp_valid), 0);
    chk("post_rst_idle", 32'(idle), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
